// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU request/done handshake plus RAM bus for mem_access_unit.
//   CPU side : req, req_write, req_addr, req_len, wdata -> unit; busy, wdata_ready,
//              rdata, rdata_valid, done, error <- unit
//   RAM side : ram_address, ram_wdata, ram_write, ram_select <- unit; ram_rdata -> unit
//   modport slave is the unit, modport master is the CPU/RAM environment.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              req;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              busy;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_write;
  logic              ram_select;
  modport master (
    output req, req_write, req_addr, req_len, wdata, ram_rdata,
    input  busy, wdata_ready, rdata, rdata_valid, done, error,
           ram_address, ram_wdata, ram_write, ram_select
  );
  modport slave (
    input  req, req_write, req_addr, req_len, wdata, ram_rdata,
    output busy, wdata_ready, rdata, rdata_valid, done, error,
           ram_address, ram_wdata, ram_write, ram_select
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: single/burst read-write sequencer for the 32-bit data RAM.
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : mem_access_unit_if.slave (CPU request/done handshake and RAM bus)
//   MAU_WRAP_CHECK_EN : when defined, bursts crossing the top of the address space
//                       are rejected with done+error and no RAM cycle.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  mem_access_unit_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_CAPT, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic              r_rvalid;
  logic              w_last, w_range_err;
  assign w_last = r_cnt == r_len;
`ifdef MAU_WRAP_CHECK_EN
  logic              r_err;
  logic [ADDR_W:0]   w_end;
  // carry out of the last-beat address means the burst would wrap
  assign w_end       = {1'b0, bus.req_addr} + (ADDR_W+1)'(bus.req_len);
  assign w_range_err = w_end[ADDR_W];
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_err <= 1'b0;
    else if (r_state == IDLE && bus.req) r_err <= w_range_err;
  end
  assign bus.error = r_state == DONE && r_err;
`else
  assign w_range_err = 1'b0;
  assign bus.error   = 1'b0;
`endif
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (bus.req) w_next = w_range_err ? DONE : bus.req_write ? W_SETUP : R_ADDR;
      W_SETUP:  w_next = W_STROBE;
      W_STROBE: w_next = W_HOLD;
      W_HOLD:   w_next = w_last ? DONE : W_SETUP;
      R_ADDR:   w_next = R_CAPT;
      R_CAPT:   w_next = w_last ? DONE : R_ADDR;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= r_state == R_CAPT;
      if (r_state == IDLE && bus.req) begin
        r_addr <= bus.req_addr;
        r_len  <= bus.req_len;
        r_cnt  <= '0;
      end
      if (r_state == W_SETUP) r_wdata <= bus.wdata;
      if (r_state == R_CAPT) r_rdata <= bus.ram_rdata;
      // advance only after the beat's strobe/capture so address never moves under ram_write
      if ((r_state == W_HOLD || r_state == R_CAPT) && !w_last) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt + LEN_W'(1);
      end
    end
  end
  assign bus.busy        = r_state != IDLE;
  assign bus.wdata_ready = r_state == W_SETUP;
  assign bus.ram_write   = r_state == W_STROBE;
  assign bus.ram_select  = !(r_state == IDLE || r_state == DONE);
  assign bus.done        = r_state == DONE;
  assign bus.rdata_valid = r_rvalid;
  assign bus.rdata       = r_rdata;
  assign bus.ram_address = r_addr;
  assign bus.ram_wdata   = r_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random bursts checked against a word-array memory model.
module tb_mem_access_unit;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();
  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .bus(bus)
  );
  logic [DW-1:0] ram [0:65535];
  logic [DW-1:0] model [0:65535];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_select && bus.ram_write) ram[bus.ram_address] <= bus.ram_wdata;
    ram_q <= ram[bus.ram_address];
  end
  assign bus.ram_rdata = ram_q;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, sel_cnt = 0, bad_we = 0;
  int we_first = -1, done_at = -1, rv_last = -1;
  logic [AW+DW-1:0] wr_seen [$];
  logic [DW-1:0] rd_seen [$];
  logic [DW-1:0] wq [0:15];
  always @(negedge clk) begin
    cyc++;
    if (bus.ram_write) begin
      wr_seen.push_back({bus.ram_address, bus.ram_wdata});
      if (we_first < 0) we_first = cyc;
    end
    if (bus.rdata_valid) begin
      rd_seen.push_back(bus.rdata);
      rv_last = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      if (done_at < 0) done_at = cyc;
    end
    if (bus.error) err_cnt++;
    if (bus.ram_select) sel_cnt++;
    if (bus.ram_write && !bus.ram_select) bad_we++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_burst(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input bit poke, input string tag);
    int b = 0;
    int n = int'(l) + 1;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int s0 = sel_cnt;
    int acc = 0;
    bit fin = 0;
    bit werr = (int'(a) + int'(l)) > 65535;
    logic [AW-1:0] ak;
`ifndef MAU_WRAP_CHECK_EN
    werr = 0;
`endif
    wr_seen.delete();
    rd_seen.delete();
    we_first = -1;
    done_at = -1;
    rv_last = -1;
    @(negedge clk);
    #1;
    bus.req = 1'b1;
    bus.req_write = wr;
    bus.req_addr = a;
    bus.req_len = l;
    @(posedge clk);
    acc = cyc;
    #1;
    bus.req = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      #1;
      bus.req = poke && (i == 2 || i == 3);
      bus.req_write = 1'($urandom);
      bus.req_addr = AW'($urandom);
      if (bus.wdata_ready) begin
        bus.wdata = wq[b[3:0]];
        b++;
      end
      if (bus.done) fin = 1;
    end
    bus.req = 1'b0;
    chk({tag, "/done_seen"}, 64'(fin), 64'(1));
    chk({tag, "/done_count"}, 64'(done_cnt - d0), 64'(1));
    chk({tag, "/we_without_sel"}, 64'(bad_we), 64'(0));
    if (werr) begin
      chk({tag, "/err_latency"}, 64'(done_at - acc), 64'(1));
      chk({tag, "/err_flag"}, 64'(err_cnt - e0), 64'(1));
      chk({tag, "/err_no_select"}, 64'(sel_cnt - s0), 64'(0));
      chk({tag, "/err_no_write"}, 64'(wr_seen.size()), 64'(0));
    end else begin
      chk({tag, "/no_error"}, 64'(err_cnt - e0), 64'(0));
      chk({tag, "/addr_hold"}, 64'(bus.ram_address), 64'(AW'(a + AW'(l))));
      if (wr) begin
        chk({tag, "/wr_count"}, 64'(wr_seen.size()), 64'(n));
        chk({tag, "/wr_latency"}, 64'(we_first - acc), 64'(2));
        chk({tag, "/wr_done_lat"}, 64'(done_at - acc), 64'(3 * n + 1));
        chk({tag, "/wr_no_rvalid"}, 64'(rd_seen.size()), 64'(0));
        for (int k = 0; k < n; k++) begin
          ak = a + AW'(k);
          if (k < wr_seen.size()) chk({tag, "/wr_beat"}, 64'(wr_seen[k]), 64'({ak, wq[k]}));
          model[ak] = wq[k];
        end
      end else begin
        chk({tag, "/rd_count"}, 64'(rd_seen.size()), 64'(n));
        chk({tag, "/rd_done_lat"}, 64'(done_at - acc), 64'(2 * n + 1));
        chk({tag, "/rd_last_valid"}, 64'(rv_last - acc), 64'(2 * n + 1));
        chk({tag, "/rd_no_write"}, 64'(wr_seen.size()), 64'(0));
        for (int k = 0; k < n && k < rd_seen.size(); k++) begin
          ak = a + AW'(k);
          chk({tag, "/rd_beat"}, 64'(rd_seen[k]), 64'(model[ak]));
        end
      end
    end
  endtask
  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = '0;
      model[i] = '0;
    end
    bus.req = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_len = '0;
    bus.wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset/ctrl", 64'({bus.busy, bus.wdata_ready, bus.rdata_valid, bus.done,
                           bus.error, bus.ram_write, bus.ram_select}), 64'(0));
    chk("reset/addr", 64'(bus.ram_address), 64'(0));
    chk("reset/rdata", 64'(bus.rdata), 64'(0));
    chk("reset/wdata", 64'(bus.ram_wdata), 64'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wq[0] = 32'hDEADBEEF;
    run_burst(1'b1, 16'h0010, 4'd0, 1'b0, "single_write");
    run_burst(1'b0, 16'h0010, 4'd0, 1'b0, "single_read");
    for (int k = 0; k < 4; k++) wq[k] = DW'(k + 1);
    run_burst(1'b1, 16'h0100, 4'd3, 1'b0, "burst_write");
    run_burst(1'b0, 16'h0100, 4'd3, 1'b0, "burst_read");
    for (int k = 0; k < 4; k++) wq[k] = $urandom;
    run_burst(1'b1, 16'hFFFE, 4'd3, 1'b0, "wrap_write");
    run_burst(1'b0, 16'h0000, 4'd1, 1'b0, "wrap_low_read");
    run_burst(1'b0, 16'h0100, 4'd3, 1'b1, "req_while_busy");
    ra = AW'($urandom_range(0, 60000));
    for (int k = 0; k < 4; k++) wq[k] = $urandom;
    @(negedge clk);
    #1;
    bus.req = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr = ra;
    bus.req_len = 4'd3;
    @(posedge clk);
    #1 bus.req = 1'b0;
    begin
      int b = 0;
      for (int i = 1; i <= 5; i++) begin
        @(negedge clk);
        #1;
        if (bus.wdata_ready) begin
          bus.wdata = wq[b];
          b++;
        end
      end
    end
    chk("rst_mid/strobe", 64'({bus.ram_write, bus.ram_select}), 64'(2'b11));
    chk("rst_mid/addr", 64'(bus.ram_address), 64'(AW'(ra + AW'(1))));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid/drop", 64'({bus.ram_write, bus.ram_select, bus.busy}), 64'(0));
    model[ra] = wq[0];
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_burst(1'b0, ra, 4'd1, 1'b0, "rst_after_read");
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 16; k++) wq[k] = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF0 + 16'($urandom_range(0, 15)))
                                        : AW'($urandom_range(0, 255));
      run_burst(1'($urandom), ra, LW'($urandom), 1'($urandom_range(0, 3) == 0), "random");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side controller for the 32-bit data RAM. It accepts single or burst read/write requests from the CPU datapath over a simple request/done handshake. It sequences the RAM's address, data, select and write lines so that the write strobe is asserted only while address and data are stable. It returns read data one beat at a time and sits between the CPU load/store stage and the RAM.

Parameters:
ADDR_W, 16, RAM address width; matches the RAM's 64K-word space.
DATA_W, 32, word width.
LEN_W, 4, burst length field width; a burst is req_len+1 beats, so the maximum is 16.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req  input  1  request strobe; sampled only in IDLE.
req_write  input  1  1 = write burst, 0 = read burst.
req_addr  input  ADDR_W  start word address.
req_len  input  LEN_W  beats minus one.
busy  output  1  high from the cycle after acceptance through the DONE cycle.
wdata  input  DATA_W  write data for the current beat.
wdata_ready  output  1  high for one cycle per write beat; wdata is consumed on that edge.
rdata  output  DATA_W  registered read data.
rdata_valid  output  1  one-cycle pulse per read beat.
done  output  1  one-cycle pulse at end of the burst.
error  output  1  qualifies done; see Optional Feature.
ram_address  output  ADDR_W  to RAM address.
ram_wdata  output  DATA_W  to RAM data_in.
ram_rdata  input  DATA_W  from RAM data_out.
ram_write  output  1  to RAM write.
ram_select  output  1  to RAM select.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - busy, wdata_ready, rdata_valid, done, error, ram_write and ram_select all go to 0.
  - ram_address, ram_wdata, rdata and the beat counter go to 0.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_CAPT, DONE.
- IDLE:
  - On req=1, latch req_addr into ram_address and latch req_len; clear the beat counter.
  - Go to W_SETUP if req_write=1, otherwise R_ADDR.
  - req in any other state is ignored and is not queued.
- W_SETUP: ram_select=1, ram_write=0, wdata_ready=1. wdata is registered into ram_wdata at the end of the cycle.
- W_STROBE: ram_select=1, ram_write=1. This is exactly one cycle per beat.
- W_HOLD: ram_select=1, ram_write=0. Address and data are held.
  - If beat counter == latched length, go to DONE.
  - Otherwise increment ram_address and the beat counter, then go to W_SETUP.
  - Write beat = 3 cycles.
- R_ADDR: ram_select=1, ram_write=0.
- R_CAPT: ram_select=1.
  - ram_rdata is registered into rdata at the end of the cycle; rdata_valid=1 in the following cycle.
  - If last beat, go to DONE; otherwise increment address and counter, then go to R_ADDR.
  - Read beat = 2 cycles.
- DONE: ram_select=0, done=1, busy=1. Return to IDLE the next cycle. A new req is accepted no earlier than IDLE.
- Latency, counted in cycles after the acceptance edge:
  - Single write: ram_write in cycle 2, done in cycle 4.
  - Single read: done and rdata_valid both in cycle 3.
- ram_address holds its last value while idle. ram_write is never 1 while ram_select is 0.
- Address increments modulo 2^ADDR_W unless the optional feature is enabled.

Optional Feature:
- Macro: MAU_WRAP_CHECK_EN.
- Defined: at acceptance, if req_addr + req_len > 2^ADDR_W−1, no RAM cycle is issued. The FSM goes IDLE → DONE, with done=1 and error=1 for that one cycle; error is 0 on every other done.
- Undefined: no check is made, addresses wrap to 0, and error is tied to 0.

Test Plan:
1. Single write: req_write=1, addr 0x0010, len 0, wdata 0xDEADBEEF → ram_write high exactly one cycle with ram_address=0x0010 and ram_wdata=0xDEADBEEF; done in cycle 4.
2. Single read of 0x0010 after test 1 → rdata=0xDEADBEEF with rdata_valid and done in cycle 3; ram_write stays 0 throughout.
3. Burst write at 0x0100, len 3, data 1,2,3,4 (advance on wdata_ready), then burst read → four ram_write pulses at 0x0100–0x0103; four rdata_valid pulses carrying 1,2,3,4 in order; one done per burst.
4. Wrap case, addr 0xFFFE, len 3:
   - With MAU_WRAP_CHECK_EN: ram_select never asserts; done=1 and error=1 one cycle after acceptance.
   - Without: writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; error=0.
5. Reset during W_STROBE of beat 2 → ram_write, ram_select and busy drop to 0 asynchronously; a subsequent single read completes normally.
6. req pulsed while busy during a len-3 read → ignored; exactly one done and four rdata_valid pulses.
